// File: rtl/calc1_port_driver_if.sv
// calc1_port_driver_if: bundles the signals around one calc1 port driver.
//   op_*   : operation request (valid/ready), offered by the requester
//   req_*  : serialised two-cycle request driven towards calc1
//   out_*  : calc1 response inputs for this port
//   rsp_*  : captured response (valid/ready) returned to the requester
// Modports: slave = driver view, master = requester/port-model view.
interface calc1_port_driver_if;
    logic        op_valid;
    logic        op_ready;
    logic [0:3]  op_cmd;
    logic [0:31] op_data1;
    logic [0:31] op_data2;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  out_resp;
    logic [0:31] out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:1]  rsp_code;
    logic [0:31] rsp_data;
    logic        rsp_timeout;

    modport slave (
        input  op_valid, op_cmd, op_data1, op_data2, out_resp, out_data, rsp_ready,
        output op_ready, req_cmd_out, req_data_out, rsp_valid, rsp_code, rsp_data, rsp_timeout
    );

    modport master (
        output op_valid, op_cmd, op_data1, op_data2, out_resp, out_data, rsp_ready,
        input  op_ready, req_cmd_out, req_data_out, rsp_valid, rsp_code, rsp_data, rsp_timeout
    );
endinterface

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: upstream request sequencer for one calc1 port.
// Takes one complete operation, drives it onto calc1 as cmd+data1 then data2,
// waits for out_resp (bounded by TIMEOUT_CYCLES), and holds the response until
// it is consumed. At most one operation is outstanding.
// Ports:
//   c_clk, reset_n : clock, asynchronous active-low reset
//   bus            : calc1_port_driver_if.slave (op, req, out, rsp groups)
//   busy           : FSM not idle
//   timeout_count  : saturating count of timeouts since reset
module calc1_port_driver #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int CNT_W          = 8
) (
    input  logic                c_clk,
    input  logic                reset_n,
    calc1_port_driver_if.slave  bus,
    output logic                busy,
    output logic [0:CNT_W-1]    timeout_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_OPND2,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    logic        ready_en;   // keeps op_ready low until the first edge after reset
    logic [0:31] data2_q;
    logic [7:0]  timer;
    logic [7:0]  timer_nxt;
    logic        op_fire;

    // timer holds the count of completed WAIT cycles; timer_nxt is the
    // 1-based index of the current WAIT cycle.
    assign timer_nxt    = timer + 8'd1;
    assign bus.op_ready = ready_en && (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign op_fire      = bus.op_valid && bus.op_ready;

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            ready_en         <= 1'b0;
            data2_q          <= '0;
            timer            <= '0;
            timeout_count    <= '0;
            bus.req_cmd_out  <= '0;
            bus.req_data_out <= '0;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_code     <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_timeout  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (op_fire) begin
                        // cmd and data1 go straight into the request registers
                        bus.req_cmd_out  <= bus.op_cmd;
                        bus.req_data_out <= bus.op_data1;
                        data2_q          <= bus.op_data2;
                        state            <= S_CMD;
                    end
                end
                S_CMD: begin
                    bus.req_cmd_out  <= '0;
                    bus.req_data_out <= data2_q;
                    state            <= S_OPND2;
                end
                S_OPND2: begin
                    bus.req_data_out <= '0;
                    timer            <= '0;
                    state            <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer_nxt;
                    // A real response beats an expiry in the same cycle.
                    if (bus.out_resp != 2'b00) begin
                        bus.rsp_code    <= bus.out_resp;
                        bus.rsp_data    <= bus.out_data;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        state           <= S_HOLD;
                    end else if (timer_nxt == 8'(TIMEOUT_CYCLES)) begin
                        bus.rsp_code    <= '0;
                        bus.rsp_data    <= '0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        if (!(&timeout_count))
                            timeout_count <= timeout_count + CNT_W'(1);
                        state           <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid   <= 1'b0;
                        bus.rsp_timeout <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc1_port_driver.sv
module tb_calc1_port_driver;

    logic       c_clk = 1'b0;
    logic       reset_n;
    logic       busy;
    logic [0:7] timeout_count;
    int         tests = 0;
    int         fails = 0;

    calc1_port_driver_if ifc ();

    calc1_port_driver #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .c_clk         (c_clk),
        .reset_n       (reset_n),
        .bus           (ifc),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    always #5 c_clk = ~c_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
    endtask

    // Offer an op in IDLE, follow it through CMD and OPND2; returns in WAIT cycle 1.
    task automatic send_op(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2);
        chk("idle_ready", 32'(ifc.op_ready), 32'd1);
        ifc.op_valid = 1'b1;
        ifc.op_cmd   = cmd;
        ifc.op_data1 = d1;
        ifc.op_data2 = d2;
        step();
        ifc.op_valid = 1'b0;
        chk("cmd_cyc_cmd",  32'(ifc.req_cmd_out), 32'(cmd));
        chk("cmd_cyc_data", ifc.req_data_out, d1);
        chk("cmd_cyc_rdy",  32'(ifc.op_ready), 32'd0);
        step();
        chk("op2_cyc_cmd",  32'(ifc.req_cmd_out), 32'd0);
        chk("op2_cyc_data", ifc.req_data_out, d2);
        step();
        chk("wait_cmd",  32'(ifc.req_cmd_out), 32'd0);
        chk("wait_data", ifc.req_data_out, 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
    endtask

    // Port model answers on WAIT cycle n (n>=1); returns in the first HOLD cycle.
    task automatic respond(input int n, input logic [1:0] resp, input logic [31:0] data);
        for (int i = 1; i < n; i++) begin
            chk("wait_no_rsp", 32'(ifc.rsp_valid), 32'd0);
            step();
        end
        ifc.out_resp = resp;
        ifc.out_data = data;
        step();
        ifc.out_resp = 2'b00;
        ifc.out_data = 32'h0;
        chk("hold_valid",   32'(ifc.rsp_valid), 32'd1);
        chk("hold_code",    32'(ifc.rsp_code), 32'(resp));
        chk("hold_data",    ifc.rsp_data, data);
        chk("hold_timeout", 32'(ifc.rsp_timeout), 32'd0);
        chk("hold_rdy",     32'(ifc.op_ready), 32'd0);
    endtask

    task automatic handshake();
        ifc.rsp_ready = 1'b1;
        step();
        ifc.rsp_ready = 1'b0;
        chk("post_hs_ready", 32'(ifc.op_ready), 32'd1);
        chk("post_hs_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("post_hs_busy",  32'(busy), 32'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        ifc.op_valid  = 1'b0;
        ifc.op_cmd    = 4'h0;
        ifc.op_data1  = 32'h0;
        ifc.op_data2  = 32'h0;
        ifc.out_resp  = 2'b00;
        ifc.out_data  = 32'h0;
        ifc.rsp_ready = 1'b0;

        // Reset state
        step();
        chk("rst_ready", 32'(ifc.op_ready), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_cmd",   32'(ifc.req_cmd_out), 32'd0);
        chk("rst_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("rst_tcnt",  32'(timeout_count), 32'd0);
        reset_n = 1'b1;
        chk("rel_ready_low", 32'(ifc.op_ready), 32'd0);
        step();
        chk("rel_ready_high", 32'(ifc.op_ready), 32'd1);

        // Add, answered on WAIT cycle 3
        send_op(4'd1, 32'h0000_0001, 32'h01FF_FFFF);
        respond(3, 2'd1, 32'h0200_0000);
        handshake();

        // Invalid cmd passes through, error response captured
        send_op(4'd3, 32'h1, 32'h0);
        respond(1, 2'd2, 32'h0);
        handshake();

        // Overflow
        send_op(4'd1, 32'hFFFF_FFFF, 32'h1);
        respond(2, 2'd2, 32'h0);
        chk("ovf_tcnt", 32'(timeout_count), 32'd0);
        handshake();

        // Silent port: timeout after WAIT cycle 8
        send_op(4'd1, 32'h5, 32'h6);
        for (int i = 1; i < 8; i++) step();
        chk("to_w8_valid", 32'(ifc.rsp_valid), 32'd0);
        step();
        chk("to_valid",   32'(ifc.rsp_valid), 32'd1);
        chk("to_flag",    32'(ifc.rsp_timeout), 32'd1);
        chk("to_code",    32'(ifc.rsp_code), 32'd0);
        chk("to_data",    ifc.rsp_data, 32'd0);
        chk("to_tcnt",    32'(timeout_count), 32'd1);
        handshake();

        // Response exactly on WAIT cycle 8 wins over expiry
        send_op(4'd2, 32'h9, 32'h4);
        respond(8, 2'd1, 32'h0000_0055);
        chk("edge_tcnt", 32'(timeout_count), 32'd1);

        // Backpressure in HOLD with a stray response
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ifc.out_resp = 2'd1;
                ifc.out_data = 32'hDEAD_0000;
            end
            step();
            ifc.out_resp = 2'b00;
            ifc.out_data = 32'h0;
            chk("bp_data",  ifc.rsp_data, 32'h0000_0055);
            chk("bp_code",  32'(ifc.rsp_code), 32'd1);
            chk("bp_valid", 32'(ifc.rsp_valid), 32'd1);
            chk("bp_ready", 32'(ifc.op_ready), 32'd0);
        end
        handshake();
        send_op(4'd2, 32'h10, 32'h20);
        respond(1, 2'd1, 32'h30);
        handshake();

        // Reset mid-WAIT
        send_op(4'd2, 32'hF, 32'h1);
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cmd",   32'(ifc.req_cmd_out), 32'd0);
        chk("mid_rst_data",  ifc.req_data_out, 32'd0);
        chk("mid_rst_valid", 32'(ifc.rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(ifc.op_ready), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_tcnt",  32'(timeout_count), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(ifc.rsp_valid), 32'd0);
        send_op(4'd2, 32'hF, 32'h1);
        respond(1, 2'd1, 32'hE);
        handshake();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc1_port_driver.md
Name: calc1_port_driver

Overview:
- Upstream request sequencer for one calc1 port; one instance per port (1-4).
- Accepts a complete operation (cmd, operand1, operand2) on a valid/ready interface and serialises it onto the calc1 two-cycle request protocol.
- Waits for the port's out_resp, then returns response code and data on a valid/ready response interface.
- Applies a bounded timeout so a silent port never hangs the bench or system.

Parameters:
TIMEOUT_CYCLES, 32, max WAIT-state cycles before a timeout response is generated (2..255)
CNT_W, 8, width of the saturating timeout counter

Ports:
c_clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous reset, active-low
op_valid  in  1  operation offered
op_ready  out  1  driver can accept operation
op_cmd  in  [0:3]  calc1 command, forwarded unmodified
op_data1  in  [0:31]  operand 1, bit 0 = MSB
op_data2  in  [0:31]  operand 2, bit 0 = MSB
req_cmd_out  out  [0:3]  to calc1 reqN_cmd_in
req_data_out  out  [0:31]  to calc1 reqN_data_in
out_resp  in  [0:1]  from calc1 out_respN
out_data  in  [0:31]  from calc1 out_dataN
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_code  out  [0:1]  captured out_resp; 0 on timeout
rsp_data  out  [0:31]  captured out_data; 0 on timeout
rsp_timeout  out  1  response is a timeout, qualified by rsp_valid
busy  out  1  state != IDLE
timeout_count  out  [0:CNT_W-1]  saturating count of timeouts since reset

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0, including op_ready; timer and timeout_count cleared.
  - op_ready rises in the first cycle after release.
  - Reset mid-operation abandons the op with no response; req_cmd_out returns to 0 immediately.
- FSM states: IDLE, CMD, OPND2, WAIT, HOLD.
- IDLE:
  - op_ready=1; req_cmd_out=0, req_data_out=0.
  - On op_valid&&op_ready at edge k: latch cmd/data1/data2 and go to CMD.
- CMD (cycle k+1):
  - req_cmd_out=latched cmd, req_data_out=data1. Always advance to OPND2.
- OPND2 (cycle k+2):
  - req_cmd_out=0, req_data_out=data2. Always advance to WAIT.
  - Timer loads 0.
- WAIT:
  - Drive cmd=0, data=0; timer increments each cycle (first WAIT cycle = 1).
  - out_resp!=0: capture rsp_code=out_resp, rsp_data=out_data, rsp_timeout=0; go to HOLD.
  - Timer==TIMEOUT_CYCLES with out_resp==0: rsp_code=0, rsp_data=0, rsp_timeout=1; increment timeout_count (saturate at all-ones); go to HOLD.
  - Response and expiry in the same cycle: response wins, no timeout.
- HOLD:
  - rsp_valid=1; rsp_* registers are stable.
  - On rsp_valid&&rsp_ready, go to IDLE.
  - out_resp during HOLD, CMD or OPND2 is a stray and is ignored; no register changes.
- op_ready is 0 in every state except IDLE; no pipelining, at most one op outstanding.
- Minimum op-to-op spacing is 5 cycles (IDLE, CMD, OPND2, ≥1 WAIT, HOLD).
- No command validation: invalid cmds (0, 3, 4, 7+) pass through, so calc1 error responses are observable.
- All outputs are registered except op_ready and busy, which decode directly from the state register.

Test Plan:
1. Add: op cmd=1, d1=0x00000001, d2=0x01FFFFFF; port model returns resp=1, data=0x02000000 on the 3rd WAIT cycle -> req_cmd_out sequence 1,0,0 with data 0x1, 0x01FFFFFF, 0; rsp_valid with code 1, data 0x02000000, rsp_timeout 0.
2. Overflow: cmd=1, d1=0xFFFFFFFF, d2=0x1; model returns resp=2 -> rsp_code 2, rsp_timeout 0, timeout_count unchanged.
3. Timeout: TIMEOUT_CYCLES=8, model silent -> rsp_valid asserted in the cycle after WAIT cycle 8, code 0, data 0, rsp_timeout 1, timeout_count 1. Also cover response exactly on WAIT cycle 8 -> normal response, no timeout.
4. Backpressure: rsp_ready low 5 cycles; stray resp=1, data=0xDEAD0000 injected during HOLD -> rsp_data unchanged, op_ready 0 throughout. Handshake occurs -> op_ready 1 next cycle; second op accepted.
5. Reset mid-WAIT: reset_n low for 1 cycle -> all outputs 0 asynchronously, no rsp_valid. Next op (cmd=2, 0xF - 0x1) completes normally with resp=1, data 0xE.
6. Invalid cmd=3, d1=0x1, d2=0x0 -> req_cmd_out=3 in CMD cycle; model resp=2 captured as rsp_code 2.
